fwd_scoreboard: RTL and testbench

Parametrised decode-stage forwarding and hazard unit for the pipelined MIPS core. It tracks in-flight register writers across NSTAGE downstream stages (E, M, W by default) in an internal shift register. For each of NUM_RD decode read ports it selects the youngest ready writer's value, or asserts stall when the value will not be ready by the consumer's Tuse. It replaces the fixed two-port combinational D-stage forward mux and the separate stall logic.

---
 rtl/fwd_pkg.sv | 32 +++
 rtl/fwd_port_sel.sv | 51 +++++
 rtl/fwd_scoreboard.sv | 103 ++++++++++
 tb/tb_fwd_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the decode-stage forwarding scoreboard.
// Holds stage index constants, the default-width scoreboard entry layout and
// the Tuse/Tnew values used by the decoder for each instruction class.
package fwd_pkg;

    // Stage indices relative to D: E is the youngest tracked stage.
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    // Default field widths for the classic three-stage tracking window.
    localparam int FWD_AW = 5;
    localparam int FWD_TW = 2;

    // One in-flight register writer.
    typedef struct packed {
        logic              v;
        logic [FWD_AW-1:0] wa;
        logic [FWD_TW-1:0] tnew;
    } fwd_entry_t;

    // Cycles (after D) until an operand is consumed.
    localparam logic [FWD_TW-1:0] TUSE_BR  = 2'd0;
    localparam logic [FWD_TW-1:0] TUSE_ALU = 2'd1;
    localparam logic [FWD_TW-1:0] TUSE_ST  = 2'd2;

    // Cycles (measured at E entry) until a result can be forwarded.
    localparam logic [FWD_TW-1:0] TNEW_ALU  = 2'd1;
    localparam logic [FWD_TW-1:0] TNEW_LD   = 2'd2;
    localparam logic [FWD_TW-1:0] TNEW_LINK = 2'd0;

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding select.
// Finds the youngest valid entry writing the requested register and decides
// whether to forward that stage's data, stall, or let a later stage forward.
// Ports:
//   ent_v/ent_wa/ent_tnew : flattened scoreboard entries, index 0 = E
//   rd_addr/rd_tuse       : source register and its use deadline
//   rf_rdata              : register file data for this port
//   stg_wd                : per-stage candidate write data
//   data/hit/stall_i      : selected operand, forward flag, port stall
module fwd_port_sel #(
    parameter int NSTAGE = 3,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = 2
) (
    input  logic [NSTAGE-1:0]    ent_v,
    input  logic [NSTAGE*AW-1:0] ent_wa,
    input  logic [NSTAGE*TW-1:0] ent_tnew,
    input  logic [AW-1:0]        rd_addr,
    input  logic [TW-1:0]        rd_tuse,
    input  logic [DW-1:0]        rf_rdata,
    input  logic [NSTAGE*DW-1:0] stg_wd,
    output logic [DW-1:0]        data,
    output logic                 hit,
    output logic                 stall_i
);

    logic found;

    // Walk from youngest to oldest; the first match decides and older
    // matches are masked. Register 0 is hardwired and never forwarded.
    always_comb begin
        data    = rf_rdata;
        hit     = 1'b0;
        stall_i = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (!found && ent_v[k] && (ent_wa[k*AW +: AW] == rd_addr) &&
                (rd_addr != '0)) begin
                found = 1'b1;
                if (ent_tnew[k*TW +: TW] == '0) begin
                    data = stg_wd[k*DW +: DW];
                    hit  = 1'b1;
                end else if (ent_tnew[k*TW +: TW] > rd_tuse) begin
                    stall_i = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding and hazard unit.
// Tracks in-flight register writers across NSTAGE stages after D and, for each
// read port, selects the youngest ready writer or requests a stall.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   freeze, flush   : external hold, and invalidate-all on exception/eret
//   iss_*           : writer being issued from D (valid, dest, Tnew)
//   rd_addr/rd_tuse : per-port source register and use deadline
//   rf_rdata        : per-port register file data
//   stg_wd          : per-stage candidate write data
//   rd_data/fwd_hit : per-port forwarded operand and forward flag
//   stall           : hold PC and D, bubble into E
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NSTAGE = 3,
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int TW     = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_wa,
    input  logic [TW-1:0]        iss_tnew,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic [NUM_RD*TW-1:0] rd_tuse,
    input  logic [NUM_RD*DW-1:0] rf_rdata,
    input  logic [NSTAGE*DW-1:0] stg_wd,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    fwd_hit,
    output logic                 stall
);

    localparam logic [TW-1:0] TNEW_MAX = TW'(NSTAGE - 1);

    logic [NSTAGE-1:0]    ent_v;
    logic [NSTAGE*AW-1:0] ent_wa;
    logic [NSTAGE*TW-1:0] ent_tnew;
    logic [NSTAGE*TW-1:0] tnew_dec;
    logic [TW-1:0]        iss_tnew_c;
    logic [NUM_RD-1:0]    port_stall;

    // A writer can never need longer than the tracking window to produce.
    assign iss_tnew_c = (iss_tnew > TNEW_MAX) ? TNEW_MAX : iss_tnew;

    // Each entry's Tnew as it will appear one stage later, floored at zero.
    always_comb begin
        tnew_dec = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (ent_tnew[k*TW +: TW] != '0) begin
                tnew_dec[k*TW +: TW] = ent_tnew[k*TW +: TW] - TW'(1);
            end
        end
    end

    // Scoreboard shift register. Flush wins over freeze so an exception is
    // never lost while a multiply holds the pipe; a stall issues a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_v    <= '0;
            ent_wa   <= '0;
            ent_tnew <= '0;
        end else if (flush) begin
            ent_v <= '0;
        end else if (!freeze) begin
            ent_v[STG_E]           <= iss_valid & ~stall;
            ent_wa[0 +: AW]        <= iss_wa;
            ent_tnew[0 +: TW]      <= iss_tnew_c;
            for (int k = 1; k < NSTAGE; k++) begin
                ent_v[k]             <= ent_v[k-1];
                ent_wa[k*AW +: AW]   <= ent_wa[(k-1)*AW +: AW];
                ent_tnew[k*TW +: TW] <= tnew_dec[(k-1)*TW +: TW];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        fwd_port_sel #(
            .NSTAGE(NSTAGE),
            .DW    (DW),
            .AW    (AW),
            .TW    (TW)
        ) u_sel (
            .ent_v   (ent_v),
            .ent_wa  (ent_wa),
            .ent_tnew(ent_tnew),
            .rd_addr (rd_addr[i*AW +: AW]),
            .rd_tuse (rd_tuse[i*TW +: TW]),
            .rf_rdata(rf_rdata[i*DW +: DW]),
            .stg_wd  (stg_wd),
            .data    (rd_data[i*DW +: DW]),
            .hit     (fwd_hit[i]),
            .stall_i (port_stall[i])
        );
    end

    assign stall = |port_stall;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed testbench for fwd_scoreboard with hand-computed expectations.
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    localparam int NUM_RD = 2;
    localparam int NSTAGE = 3;
    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int TW     = 2;

    localparam logic [31:0] RF0 = 32'h0000_1111;
    localparam logic [31:0] RF1 = 32'h0000_2222;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 freeze;
    logic                 flush;
    logic                 iss_valid;
    logic [AW-1:0]        iss_wa;
    logic [TW-1:0]        iss_tnew;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*TW-1:0] rd_tuse;
    logic [NUM_RD*DW-1:0] rf_rdata;
    logic [NSTAGE*DW-1:0] stg_wd;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    fwd_hit;
    logic                 stall;

    int checks = 0;
    int errors = 0;

    fwd_scoreboard #(
        .NUM_RD(NUM_RD),
        .NSTAGE(NSTAGE),
        .DW    (DW),
        .AW    (AW),
        .TW    (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .freeze   (freeze),
        .flush    (flush),
        .iss_valid(iss_valid),
        .iss_wa   (iss_wa),
        .iss_tnew (iss_tnew),
        .rd_addr  (rd_addr),
        .rd_tuse  (rd_tuse),
        .rf_rdata (rf_rdata),
        .stg_wd   (stg_wd),
        .rd_data  (rd_data),
        .fwd_hit  (fwd_hit),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive the D-stage issue and both read ports.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] wa,
                                 input logic [TW-1:0] tn,
                                 input logic [AW-1:0] a0, input logic [TW-1:0] t0,
                                 input logic [AW-1:0] a1, input logic [TW-1:0] t1);
        iss_valid = v;
        iss_wa    = wa;
        iss_tnew  = tn;
        rd_addr   = {a1, a0};
        rd_tuse   = {t1, t0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flushAll();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        freeze   = 1'b0;
        flush    = 1'b0;
        rf_rdata = {RF1, RF0};
        stg_wd   = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, TUSE_BR, 5'd8, TUSE_BR);
        tick();
        tick();
        #1;
        checkOutput("reset_stall", {31'd0, stall}, 32'd0);
        checkOutput("reset_hit", {30'd0, fwd_hit}, 32'd0);
        checkOutput("reset_data0", rd_data[31:0], RF0);
        checkOutput("reset_data1", rd_data[63:32], RF1);
        reset = 1'b0;
        tick();

        // lw $8 then beq $8: two stall cycles, then forward from W.
        applyStimulus(1'b1, 5'd8, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, TUSE_BR, 5'd0, 2'd0);
        #1 checkOutput("lw_br_stall1", {31'd0, stall}, 32'd1);
        checkOutput("lw_br_data_stall", rd_data[31:0], RF0);
        tick();
        checkOutput("lw_br_stall2", {31'd0, stall}, 32'd1);
        tick();
        stg_wd[2*DW +: DW] = 32'h0000_1234;
        #1 checkOutput("lw_br_stall3", {31'd0, stall}, 32'd0);
        checkOutput("lw_br_data", rd_data[31:0], 32'h0000_1234);
        checkOutput("lw_br_hit", {31'd0, fwd_hit[0]}, 32'd1);
        tick();
        checkOutput("w_dropoff_hit", {31'd0, fwd_hit[0]}, 32'd0);
        checkOutput("w_dropoff_data", rd_data[31:0], RF0);

        // lw $8 then addu $9,$8: exactly one stall cycle.
        flushAll();
        applyStimulus(1'b1, 5'd8, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd9, TNEW_ALU, 5'd8, TUSE_ALU, 5'd0, 2'd0);
        #1 checkOutput("lw_alu_stall1", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("lw_alu_stall2", {31'd0, stall}, 32'd0);
        checkOutput("lw_alu_hit", {31'd0, fwd_hit[0]}, 32'd0);
        checkOutput("lw_alu_data", rd_data[31:0], RF0);

        // jal $31 then jr $31: forward PC+8 from E with no stall.
        flushAll();
        applyStimulus(1'b1, 5'd31, TNEW_LINK, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        stg_wd[0 +: DW] = 32'h0000_3008;
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd31, TUSE_BR, 5'd0, 2'd0);
        #1 checkOutput("jal_jr_data", rd_data[31:0], 32'h0000_3008);
        checkOutput("jal_jr_hit", {31'd0, fwd_hit[0]}, 32'd1);
        checkOutput("jal_jr_stall", {31'd0, stall}, 32'd0);

        // $5 in both E and M: youngest (E) wins on port 1.
        flushAll();
        applyStimulus(1'b1, 5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        stg_wd[0 +: DW]  = 32'h0000_AAAA;
        stg_wd[DW +: DW] = 32'h0000_BBBB;
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd5, TUSE_ALU);
        #1 checkOutput("youngest_data1", rd_data[63:32], 32'h0000_AAAA);
        checkOutput("youngest_hit1", {31'd0, fwd_hit[1]}, 32'd1);
        checkOutput("youngest_hit0", {31'd0, fwd_hit[0]}, 32'd0);

        // Young unready $5 masks an older ready $5: stall rather than forward.
        flushAll();
        applyStimulus(1'b1, 5'd5, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b1, 5'd5, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 5'd5, TUSE_BR);
        #1 checkOutput("mask_old_stall", {31'd0, stall}, 32'd1);
        checkOutput("mask_old_hit1", {31'd0, fwd_hit[1]}, 32'd0);

        // Writer to $0 never matches.
        flushAll();
        applyStimulus(1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd0, TUSE_BR, 5'd0, TUSE_BR);
        #1 checkOutput("r0_data0", rd_data[31:0], RF0);
        checkOutput("r0_hit0", {31'd0, fwd_hit[0]}, 32'd0);

        // iss_tnew of 3 is clamped to 2: only one stall cycle for tuse=1.
        flushAll();
        applyStimulus(1'b1, 5'd7, 2'd3, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd7, TUSE_ALU, 5'd0, 2'd0);
        #1 checkOutput("clamp_stall1", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("clamp_stall2", {31'd0, stall}, 32'd0);

        // Hazard held by freeze for three cycles, then resolves normally.
        flushAll();
        stg_wd[2*DW +: DW] = 32'h0000_5678;
        applyStimulus(1'b1, 5'd8, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, TUSE_BR, 5'd0, 2'd0);
        #1 checkOutput("frz_stall_pre", {31'd0, stall}, 32'd1);
        freeze = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("frz_stall_hold%0d", c), {31'd0, stall}, 32'd1);
        end
        freeze = 1'b0;
        tick();
        checkOutput("frz_stall_rel1", {31'd0, stall}, 32'd1);
        tick();
        checkOutput("frz_stall_rel2", {31'd0, stall}, 32'd0);
        checkOutput("frz_data", rd_data[31:0], 32'h0000_5678);
        checkOutput("frz_hit", {31'd0, fwd_hit[0]}, 32'd1);

        // Flush beats freeze and clears all entries in one edge.
        flushAll();
        applyStimulus(1'b1, 5'd8, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, TUSE_BR, 5'd0, 2'd0);
        #1 checkOutput("flush_pre_stall", {31'd0, stall}, 32'd1);
        flush  = 1'b1;
        freeze = 1'b1;
        tick();
        flush  = 1'b0;
        freeze = 1'b0;
        #1 checkOutput("flush_stall", {31'd0, stall}, 32'd0);
        checkOutput("flush_hit", {31'd0, fwd_hit[0]}, 32'd0);

        // Asynchronous reset mid-stall drops stall within the cycle.
        applyStimulus(1'b1, 5'd8, TNEW_LD, 5'd0, 2'd0, 5'd0, 2'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 2'd0, 5'd8, TUSE_BR, 5'd0, 2'd0);
        #1 checkOutput("areset_pre_stall", {31'd0, stall}, 32'd1);
        reset = 1'b1;
        #1 checkOutput("areset_stall", {31'd0, stall}, 32'd0);
        checkOutput("areset_data0", rd_data[31:0], RF0);
        #1 reset = 1'b0;
        tick();
        checkOutput("areset_after", {31'd0, stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
